// File: rtl/ddr3_app_arbiter.sv
// Two-requester round-robin scheduler in front of the DDR3 controller app interface.
// Read returns are steered back to their issuer through an in-order tag FIFO.
module ddr3_app_arbiter #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MASK_W    = 64,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              init_calib_complete,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic [MASK_W-1:0] rq0_wmask,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic [MASK_W-1:0] rq1_wmask,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data,
  output logic              err_orphan
);

  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              cmd_done_q, cmd_done_d;
  logic              dat_done_q, dat_done_d;
  logic              gnt_id_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic              tag_mem_q [TAG_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
  logic              err_orphan_q;

  logic fifo_full, fifo_empty, head_tag;
  logic elig0, elig1, can_grant, gnt0, gnt1;
  logic issuing, cmd_hs, dat_hs, push, pop, orphan;

  always_comb begin
    fifo_full  = (count_q == CntW'(TAG_DEPTH));
    fifo_empty = (count_q == '0);
    head_tag   = tag_mem_q[rd_ptr_q];
    elig0      = rq0_valid & (rq0_write | ~fifo_full);
    elig1      = rq1_valid & (rq1_write | ~fifo_full);
    // Gated by RST_N so no handshake can be offered while reset is held.
    can_grant  = (state_q == StIdle) & init_calib_complete & RST_N;
    gnt0       = can_grant & elig0 & (~elig1 | rr_last_q);
    gnt1       = can_grant & elig1 & (~elig0 | ~rr_last_q);
  end

  assign rq0_ready = gnt0;
  assign rq1_ready = gnt1;

  always_comb begin
    issuing      = (state_q == StIssue);
    app_en       = issuing & ~cmd_done_q;
    app_cmd      = (issuing & ~write_q) ? 3'b001 : 3'b000;
    app_addr     = addr_q;
    app_wdf_wren = issuing & write_q & ~dat_done_q;
    app_wdf_end  = app_wdf_wren;
    app_wdf_data = wdata_q;
    app_wdf_mask = wmask_q;
    cmd_hs       = app_en & app_rdy;
    dat_hs       = app_wdf_wren & app_wdf_rdy;
    push         = cmd_hs & ~write_q;
    pop          = app_rd_data_valid & ~fifo_empty;
    orphan       = app_rd_data_valid & fifo_empty;
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    cmd_done_d = cmd_done_q | cmd_hs;
    dat_done_d = dat_done_q | dat_hs;
    unique case (state_q)
      StIdle: begin
        if (gnt0 | gnt1) begin
          state_d    = StIssue;
          rr_last_d  = gnt1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
        end
      end
      StIssue: begin
        // Reads need only the command handshake.
        if (cmd_done_d & (dat_done_d | ~write_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      rr_last_q  <= 1'b1;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      gnt_id_q   <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      if (gnt0 | gnt1) begin
        gnt_id_q <= gnt1;
        write_q  <= gnt1 ? rq1_write : rq0_write;
        addr_q   <= gnt1 ? rq1_addr  : rq0_addr;
        wdata_q  <= gnt1 ? rq1_wdata : rq0_wdata;
        wmask_q  <= gnt1 ? rq1_wmask : rq0_wmask;
      end
    end
  end

  // Tag storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_id_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      rsp0_valid_q <= pop & ~head_tag;
      rsp1_valid_q <= pop & head_tag;
      if (pop & ~head_tag) rsp0_data_q <= app_rd_data;
      if (pop & head_tag)  rsp1_data_q <= app_rd_data;
      err_orphan_q <= err_orphan_q | orphan;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: arbitration vector table, directed corner sequences, and a
// memory model whose read returns feed a response scoreboard.
module tb_ddr3_app_arbiter;
  localparam int unsigned ADDR_W    = 28;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned MASK_W    = 64;
  localparam int unsigned TAG_DEPTH = 16;
  localparam int          Unlimited = 1000000;

  logic              CLK, RST_N, init_calib_complete;
  logic              rq0_valid, rq0_ready, rq0_write;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic [MASK_W-1:0] rq0_wmask;
  logic              rq1_valid, rq1_ready, rq1_write;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic [MASK_W-1:0] rq1_wmask;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_rd_data_valid;
  logic [DATA_W-1:0] app_rd_data;
  logic              err_orphan;

  ddr3_app_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .init_calib_complete(init_calib_complete),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_wmask(rq0_wmask),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_wmask(rq1_wmask),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .err_orphan(err_orphan)
  );

  typedef struct { logic [ADDR_W-1:0] addr; int due; bit orphan; } pend_t;
  typedef struct { bit tag; logic [DATA_W-1:0] data; int cyc; } exp_t;
  typedef struct { logic calib, v0, w0, v1, w1, r0, r1; } vec_t;

  pend_t pend[$];
  exp_t  exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int ret_limit = Unlimited, ret_fired = 0;
  int orphan_req = 0, orphan_done = 0, flush_req = 0, flush_seen = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {16{4'hA, a}};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Memory model and scoreboard; rq0 addresses live at 0x1xx, rq1 at 0x2xx (tag = addr[9]).
  task automatic monitor();
    pend_t p;
    exp_t  e;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("rsp_valid", {rsp1_valid, rsp0_valid}, e.tag ? 2'b10 : 2'b01);
        check("rsp_data", e.tag ? rsp1_data : rsp0_data, e.data);
      end else begin
        check("rsp_spurious", {rsp1_valid, rsp0_valid}, 2'b00);
      end
      if (flush_seen != flush_req) begin
        foreach (pend[i]) pend[i].orphan = 1'b1;
        flush_seen = flush_req;
      end
      if (app_en && app_rdy && app_cmd == 3'b001) pend.push_back('{app_addr, cyc + 5, 1'b0});
      if (pend.size() > 0 && pend[0].due <= cyc && ret_fired < ret_limit) begin
        p = pend.pop_front();
        ret_fired++;
        app_rd_data_valid = 1'b1;
        app_rd_data       = pat(p.addr);
        if (!p.orphan) exp_q.push_back('{p.addr[9], pat(p.addr), cyc + 1});
      end else if (pend.size() == 0 && orphan_done < orphan_req) begin
        orphan_done++;
        app_rd_data_valid = 1'b1;
        app_rd_data       = pat(28'h300);
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (pend.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    check("drain", pend.size() + exp_q.size(), 0);
  endtask

  vec_t vt[9];
  int   n;
  logic g;

  initial begin
    fork
      monitor();
      forever begin
        @(posedge CLK);
        cyc++;
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    RST_N = 1'b0; init_calib_complete = 1'b0;
    rq0_valid = 1'b0; rq0_write = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_wmask = '0;
    rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    #2;
    check("rst_app", {app_en, app_cmd, app_wdf_wren, app_wdf_end}, '0);
    check("rst_addr", app_addr, '0);
    check("rst_ready", {rq1_ready, rq0_ready}, 2'b00);
    check("rst_rsp", {rsp1_valid, rsp0_valid, err_orphan}, 3'b000);
    tick(); tick();
    RST_N = 1'b1;

    // Round-robin on continuous reads from both requesters.
    init_calib_complete = 1'b1;
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 28'h100;
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 28'h200;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      settle();
      if (rq0_ready || rq1_ready) begin
        check("rr_grant", {rq1_ready, rq0_ready}, (n % 2 == 0) ? 2'b01 : 2'b10);
        g = rq1_ready;
        n++;
        tick();
        if (g) rq1_addr = rq1_addr + 1'b1;
        else   rq0_addr = rq0_addr + 1'b1;
      end else begin
        tick();
      end
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    check("rr_count", n, 4);
    drain();

    // Calibration gating.
    init_calib_complete = 1'b0;
    rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h1AA; rq0_wdata = pat(28'h1AA);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("calib_ready", rq0_ready, 1'b0);
      check("calib_app_en", app_en, 1'b0);
      tick();
    end
    init_calib_complete = 1'b1;
    settle();
    check("calib_rise_ready", rq0_ready, 1'b1);
    tick();
    rq0_valid = 1'b0;
    settle();
    check("calib_issue", {app_en, app_wdf_wren, app_wdf_end, app_cmd}, 6'b111000);
    check("calib_addr", app_addr, 28'h1AA);
    tick();

    // Arbitration vector table.
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      init_calib_complete = vt[i].calib;
      rq0_valid = vt[i].v0; rq0_write = vt[i].w0; rq0_addr = 28'h140 + 28'(i);
      rq1_valid = vt[i].v1; rq1_write = vt[i].w1; rq1_addr = 28'h240 + 28'(i);
      rq0_wdata = pat(rq0_addr) ^ 512'h5; rq0_wmask = 64'(i);
      rq1_wdata = pat(rq1_addr) ^ 512'h9; rq1_wmask = 64'(i + 100);
      settle();
      check("vec_ready", {rq1_ready, rq0_ready}, {vt[i].r1, vt[i].r0});
      tick();
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      settle();
      if (vt[i].r0 || vt[i].r1) begin
        g = vt[i].r1;
        check("vec_app_en", app_en, 1'b1);
        check("vec_cmd", app_cmd, (g ? vt[i].w1 : vt[i].w0) ? 3'b000 : 3'b001);
        check("vec_addr", app_addr, g ? rq1_addr : rq0_addr);
        check("vec_wren", app_wdf_wren, g ? vt[i].w1 : vt[i].w0);
        if (g ? vt[i].w1 : vt[i].w0) begin
          check("vec_wdata", app_wdf_data, g ? pat(rq1_addr) ^ 512'h9 : pat(rq0_addr) ^ 512'h5);
          check("vec_wmask", app_wdf_mask, g ? 64'(i + 100) : 64'(i));
        end
      end else begin
        check("vec_idle", {app_en, app_wdf_wren}, 2'b00);
      end
      tick();
    end
    init_calib_complete = 1'b1;
    drain();

    // Command and data handshakes completing in either order.
    for (int s = 0; s < 2; s++) begin
      rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h150 + 28'(s);
      settle();
      check("stall_grant", rq0_ready, 1'b1);
      tick();
      for (int k = 1; k <= 6; k++) begin
        app_rdy     = (s == 0) ? (k == 5) : 1'b1;
        app_wdf_rdy = (s == 0) ? 1'b1 : (k == 5);
        settle();
        check("stall_en", app_en, (s == 0) ? (k <= 5) : (k == 1));
        check("stall_wren", app_wdf_wren, (s == 0) ? (k == 1) : (k <= 5));
        check("stall_ready", rq0_ready, k == 6);
        if (k == 6) rq0_valid = 1'b0;
        tick();
      end
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;

    // Tag FIFO full: 16 outstanding rq1 reads with returns frozen.
    ret_limit = ret_fired;
    rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 28'h260;
    n = 0;
    for (int i = 0; i < 80 && n < 16; i++) begin
      settle();
      if (rq1_ready) begin
        n++;
        tick();
        rq1_addr = rq1_addr + 1'b1;
        if (n == 16) rq1_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check("full_reads", n, 16);
    tick(); tick();
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 28'h170;
    rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 28'h270;
    settle();
    check("full_ready", {rq1_ready, rq0_ready}, 2'b10);
    tick();
    rq1_valid = 1'b0;
    tick();
    settle();
    check("full_blocked", rq0_ready, 1'b0);
    ret_limit = ret_fired + 1;
    g = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      settle();
      if (rq0_ready) begin
        g = 1'b1;
        break;
      end
    end
    check("full_release", g, 1'b1);
    tick();
    rq0_valid = 1'b0;
    tick();
    ret_limit = Unlimited;
    drain();

    // Orphan return.
    settle();
    check("orphan_pre", err_orphan, 1'b0);
    orphan_req++;
    for (int i = 0; i < 4; i++) tick();
    check("orphan_set", err_orphan, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("orphan_sticky", err_orphan, 1'b1);

    // Reset mid-ISSUE with a read still outstanding.
    ret_limit = ret_fired;
    rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 28'h180;
    tick();
    rq0_valid = 1'b0;
    tick();
    app_rdy = 1'b0;
    rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h181;
    tick();
    rq0_valid = 1'b0;
    settle();
    check("rst_mid_pre", app_en, 1'b1);
    RST_N = 1'b0;
    flush_req++;
    #1;
    check("rst_mid_app", {app_en, app_cmd, app_wdf_wren, app_wdf_end}, '0);
    check("rst_mid_addr", app_addr, '0);
    check("rst_mid_rsp", {rsp1_valid, rsp0_valid, err_orphan}, 3'b000);
    check("rst_mid_rdata", rsp0_data | rsp1_data, '0);
    tick();
    RST_N = 1'b1; app_rdy = 1'b1;
    rq0_valid = 1'b1; rq0_write = 1'b1; rq1_valid = 1'b1; rq1_write = 1'b1;
    settle();
    check("rst_tie", {rq1_ready, rq0_ready}, 2'b01);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    ret_limit = Unlimited;
    for (int i = 0; i < 10; i++) tick();
    check("rst_late_orphan", err_orphan, 1'b1);
    check("final_queues", pend.size() + exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
